// File: rtl/jk_seq_pkg.sv
// Shared types and defaults for the JK latch sequencer: opcodes, FSM states,
// and the rule for how each opcode moves the expected latch value.
package jk_seq_pkg;

  localparam int unsigned CMD_W          = 2;
  localparam int unsigned DEFAULT_DEPTH  = 4;
  localparam int unsigned DEFAULT_SETTLE = 2;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_CLR  = 2'b01,
    OP_SET  = 2'b10,
    OP_TGL  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK
  } state_e;

  // Returns {expValid, exp} after applying op; toggle keeps validity as-is
  function automatic logic [1:0] nextExp(input op_e op, input logic exp, input logic expValid);
    logic [1:0] res;
    res = {expValid, exp};
    case (op)
      OP_CLR:  res = 2'b10;
      OP_SET:  res = 2'b11;
      OP_TGL:  res = {expValid, ~exp};
      default: res = {expValid, exp};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/jk_latch_sequencer_if.sv
// Command handshake between a producer and the JK latch sequencer.
interface jk_latch_sequencer_if;

  logic                           cmd_valid;
  logic [jk_seq_pkg::CMD_W-1:0]   cmd_op;
  logic                           cmd_ready;

  modport master (output cmd_valid, output cmd_op, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, output cmd_ready);

endinterface

// File: rtl/jk_cmd_fifo.sv
// Small synchronous command FIFO with registered read/write pointers and an
// occupancy count; pushes into a full FIFO are dropped even if a pop coincides.
module jk_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             doPush;
  logic             doPop;

  assign full   = (count_q == (AW+1)'(DEPTH));
  assign empty  = (count_q == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign dout   = mem_q[rdPtr_q];

  always_comb begin
    count_d = count_q;
    if (doPush && !doPop) begin
      count_d = count_q + 1'b1;
    end else if (!doPush && doPop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= din;
  end

endmodule

// File: rtl/jk_latch_sequencer.sv
// Sequences queued opcodes onto a JK latch as single-cycle enable pulses,
// waits for the latch to settle, then checks its output against a model.
module jk_latch_sequencer
  import jk_seq_pkg::*;
#(
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned SETTLE = DEFAULT_SETTLE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  jk_latch_sequencer_if.slave        cmd,
  output logic                       j,
  output logic                       k,
  output logic                       le,
  input  logic                       q_fb,
  input  logic                       err_clr,
  output logic                       busy,
  output logic                       err,
  output logic [7:0]                 err_cnt
);

  state_e             state_q;
  op_e                op_q;
  logic [3:0]         settleCnt_q;
  logic               exp_q;
  logic               expValid_q;
  logic               le_q;
  logic               j_q;
  logic               k_q;
  logic               err_q;
  logic               err_d;
  logic [7:0]         errCnt_q;
  logic [7:0]         errCnt_d;

  logic               fifoPop;
  logic               fifoFull;
  logic               fifoEmpty;
  logic [CMD_W-1:0]   fifoDout;
  logic               mismatch;

  assign fifoPop       = (state_q == ST_IDLE) && !fifoEmpty;
  assign cmd.cmd_ready = !fifoFull;

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd.cmd_valid),
    .pop   (fifoPop),
    .din   (cmd.cmd_op),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  assign mismatch = (state_q == ST_CHECK) && expValid_q && (q_fb != exp_q);

  // A mismatch outranks a coincident clear so the event is never lost
  always_comb begin
    err_d    = err_q;
    errCnt_d = errCnt_q;
    if (mismatch) begin
      err_d    = 1'b1;
      errCnt_d = err_clr ? 8'd1 : ((errCnt_q == 8'hFF) ? errCnt_q : errCnt_q + 8'd1);
    end else if (err_clr) begin
      err_d    = 1'b0;
      errCnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_HOLD;
      settleCnt_q <= '0;
      exp_q       <= 1'b0;
      expValid_q  <= 1'b0;
      le_q        <= 1'b0;
      j_q         <= 1'b0;
      k_q         <= 1'b0;
      err_q       <= 1'b0;
      errCnt_q    <= '0;
    end else begin
      err_q    <= err_d;
      errCnt_q <= errCnt_d;
      case (state_q)
        ST_IDLE: begin
          if (!fifoEmpty) begin
            op_q    <= op_e'(fifoDout);
            le_q    <= 1'b1;
            j_q     <= fifoDout[1];
            k_q     <= fifoDout[0];
            state_q <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          le_q                  <= 1'b0;
          j_q                   <= 1'b0;
          k_q                   <= 1'b0;
          settleCnt_q           <= 4'(SETTLE - 1);
          {expValid_q, exp_q}   <= nextExp(op_q, exp_q, expValid_q);
          state_q               <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settleCnt_q == '0) begin
            state_q <= ST_CHECK;
          end else begin
            settleCnt_q <= settleCnt_q - 4'd1;
          end
        end
        ST_CHECK: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign j       = j_q;
  assign k       = k_q;
  assign le      = le_q;
  assign err     = err_q;
  assign err_cnt = errCnt_q;
  assign busy    = (state_q != ST_IDLE) || !fifoEmpty;

endmodule

// File: tb/tb_jk_latch_sequencer.sv
// Randomized and directed bench for jk_latch_sequencer driving a behavioural
// JK latch; expected timing and error state come from a cycle-indexed command log.
module tb_jk_latch_sequencer;

  localparam int DEPTH  = 4;
  localparam int SETTLE = 2;

  typedef struct {
    logic [1:0] op;
    int         acc;
    int         drv;
    int         chk;
  } cmdRec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       err_clr = 1'b0;
  logic       j, k, le, busy, err;
  logic [7:0] err_cnt;
  logic       q_fb;
  logic       latchQ = 1'b0;
  logic       forceEn = 1'b0;
  logic       forceVal = 1'b0;

  int totalChecks = 0;
  int badChecks   = 0;
  int cyc         = 0;
  int nAccepted   = 0;
  int lastDrv     = -100;
  logic mExp      = 1'b0;
  logic mValid    = 1'b0;
  logic mErr      = 1'b0;
  int   mCnt      = 0;
  cmdRec_t cmdQ[$];

  jk_latch_sequencer_if cmdIf();

  jk_latch_sequencer #(
    .DEPTH  (DEPTH),
    .SETTLE (SETTLE)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd     (cmdIf),
    .j       (j),
    .k       (k),
    .le      (le),
    .q_fb    (q_fb),
    .err_clr (err_clr),
    .busy    (busy),
    .err     (err),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign q_fb = forceEn ? forceVal : latchQ;

  // Behavioural JK latch: transparent while le is high, held otherwise
  always @(negedge clk) begin
    if (le) begin
      case ({j, k})
        2'b01:   latchQ <= 1'b0;
        2'b10:   latchQ <= 1'b1;
        2'b11:   latchQ <= ~latchQ;
        default: ;
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    totalChecks++;
    if (obs !== expv) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Reference model: each accepted command is scheduled by arithmetic on its
  // acceptance cycle and the previous command's drive cycle
  always @(negedge clk) begin
    int         occ;
    bit         expBusy;
    bit         expLe;
    logic [1:0] expJk;
    bit         modelReady;
    bit         mism;
    int         drv;
    if (!rst_n) begin
      cmdQ.delete();
      lastDrv = -100;
      mExp = 1'b0; mValid = 1'b0; mErr = 1'b0; mCnt = 0;
      checkOutput("rstReady", 32'(cmdIf.cmd_ready), 1);
      checkOutput("rstLe",    32'(le), 0);
      checkOutput("rstJk",    32'({j, k}), 0);
      checkOutput("rstBusy",  32'(busy), 0);
      checkOutput("rstErr",   32'(err), 0);
      checkOutput("rstCnt",   32'(err_cnt), 0);
    end else begin
      occ = 0; expBusy = 0; expLe = 0; expJk = 2'b00; mism = 0;
      foreach (cmdQ[i]) begin
        if (cmdQ[i].acc < cyc && cmdQ[i].drv > cyc) occ++;
        if (cmdQ[i].drv <= cyc && cyc <= cmdQ[i].chk) expBusy = 1;
        if (cmdQ[i].drv == cyc) begin
          expLe = 1;
          expJk = cmdQ[i].op;
        end
      end
      if (occ > 0) expBusy = 1;
      modelReady = (occ < DEPTH);
      checkOutput("ready",  32'(cmdIf.cmd_ready), 32'(modelReady));
      checkOutput("busy",   32'(busy), 32'(expBusy));
      checkOutput("le",     32'(le), 32'(expLe));
      checkOutput("jk",     32'({j, k}), 32'(expJk));
      checkOutput("err",    32'(err), 32'(mErr));
      checkOutput("errCnt", 32'(err_cnt), 32'(mCnt));
      if (cmdIf.cmd_valid && modelReady) begin
        drv = (cyc + 2 > lastDrv + SETTLE + 3) ? cyc + 2 : lastDrv + SETTLE + 3;
        cmdQ.push_back('{op: cmdIf.cmd_op, acc: cyc, drv: drv, chk: drv + SETTLE + 1});
        lastDrv = drv;
        nAccepted++;
      end
      foreach (cmdQ[i]) begin
        if (cmdQ[i].chk == cyc) begin
          case (cmdQ[i].op)
            2'b01:   begin mExp = 1'b0; mValid = 1'b1; end
            2'b10:   begin mExp = 1'b1; mValid = 1'b1; end
            2'b11:   mExp = ~mExp;
            default: ;
          endcase
          mism = mValid && (q_fb != mExp);
        end
      end
      if (mism) begin
        mErr = 1'b1;
        mCnt = err_clr ? 1 : ((mCnt < 255) ? mCnt + 1 : 255);
      end else if (err_clr) begin
        mErr = 1'b0;
        mCnt = 0;
      end
      while (cmdQ.size() > 0 && cmdQ[0].chk <= cyc) void'(cmdQ.pop_front());
    end
  end

  task automatic applyStimulus(input logic [1:0] op);
    int target;
    int guard;
    target = nAccepted + 1;
    guard  = 0;
    cmdIf.cmd_valid = 1'b1;
    cmdIf.cmd_op    = op;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (nAccepted < target && guard < 100);
    if (nAccepted < target) checkOutput("pushTimeout", 0, 1);
    cmdIf.cmd_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    while (cmdQ.size() > 0 && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    if (cmdQ.size() > 0) checkOutput("drainTimeout", 0, 1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int chkCyc;
    int guard;
    cmdIf.cmd_valid = 1'b0;
    cmdIf.cmd_op    = 2'b00;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // set, toggle, toggle, clear back-to-back: latch walks 1,0,1,0
    applyStimulus(2'b10);
    applyStimulus(2'b11);
    applyStimulus(2'b11);
    applyStimulus(2'b01);
    waitDrain();
    checkOutput("dirErr", 32'(err), 0);
    checkOutput("dirLatch", 32'(latchQ), 0);

    // six commands queued faster than they drain
    for (int i = 0; i < 6; i++) applyStimulus(2'($urandom_range(0, 3)));
    waitDrain();
    checkOutput("sixCount", 32'(nAccepted), 10);

    // toggle first after reset cannot be checked; a set then exposes a forced fault
    doReset();
    applyStimulus(2'b11);
    waitDrain();
    checkOutput("tglFirstErr", 32'(err), 0);
    forceEn = 1'b1; forceVal = 1'b0;
    applyStimulus(2'b10);
    waitDrain();
    checkOutput("forcedErr", 32'(err), 1);
    checkOutput("forcedCnt", 32'(err_cnt), 1);
    forceEn = 1'b0;
    err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    checkOutput("clrErr", 32'(err), 0);
    checkOutput("clrCnt", 32'(err_cnt), 0);
    forceEn = 1'b1;
    applyStimulus(2'b10);
    waitDrain();
    applyStimulus(2'b10);
    chkCyc = cmdQ[$].chk;
    guard  = 0;
    while (cyc < chkCyc && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    checkOutput("coinErr", 32'(err), 1);
    checkOutput("coinCnt", 32'(err_cnt), 1);
    forceEn = 1'b0;
    waitDrain();

    // free-running random traffic with occasional faults and clears
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      cmdIf.cmd_valid = 1'($urandom_range(0, 1));
      cmdIf.cmd_op    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) forceEn = ~forceEn;
      forceVal = 1'($urandom_range(0, 1));
      err_clr  = ($urandom_range(0, 19) == 0);
    end
    cmdIf.cmd_valid = 1'b0;
    err_clr = 1'b0;
    forceEn = 1'b0;
    waitDrain();

    // reset in the second settle cycle with three commands still queued
    applyStimulus(2'b10);
    applyStimulus(2'b01);
    applyStimulus(2'b10);
    applyStimulus(2'b11);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstLe",    32'(le), 0);
    checkOutput("midRstBusy",  32'(busy), 0);
    checkOutput("midRstReady", 32'(cmdIf.cmd_ready), 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) begin @(posedge clk); #1; end

    // many forced mismatches drive the counter into saturation
    forceEn = 1'b1; forceVal = 1'b0;
    for (int i = 0; i < 300; i++) applyStimulus(2'b10);
    waitDrain();
    checkOutput("satCnt", 32'(err_cnt), 255);
    checkOutput("satErr", 32'(err), 1);
    forceEn = 1'b0;

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
